// File: rtl/harmonic_mixer.sv
// Mixes a fundamental with weighted 2nd/3rd harmonic samples over a four-state
// accumulate-and-saturate sequence, one result per accepted input.
module harmonic_mixer #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = WIDTH + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              weight,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] s1,
    input  logic signed [WIDTH-1:0] s2,
    input  logic signed [WIDTH-1:0] s3,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] sample_out,
    output logic                    clipped,
    output logic                    dropped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD2 = 2'd1,
        ADD3 = 2'd2,
        SAT  = 2'd3
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] LP_MAX =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] LP_MIN =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [ACC_WIDTH-1:0] f_sext(
        input logic signed [WIDTH-1:0] x
    );
        return {{(ACC_WIDTH-WIDTH){x[WIDTH-1]}}, x};
    endfunction

    // Arithmetic shifts floor the result (truncate LSBs toward -inf).
    function automatic logic signed [ACC_WIDTH-1:0] f_half(
        input logic signed [WIDTH-1:0] x
    );
        logic signed [ACC_WIDTH-1:0] e;
        e = f_sext(x);
        return e >>> 1;
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] f_quarter(
        input logic signed [WIDTH-1:0] x
    );
        logic signed [ACC_WIDTH-1:0] e;
        e = f_sext(x);
        return e >>> 2;
    endfunction

    function automatic logic f_clip(input logic signed [ACC_WIDTH-1:0] a);
        return (a > LP_MAX) || (a < LP_MIN);
    endfunction

    function automatic logic signed [WIDTH-1:0] f_sat(
        input logic signed [ACC_WIDTH-1:0] a
    );
        logic signed [ACC_WIDTH-1:0] c;
        if (a > LP_MAX)
            c = LP_MAX;
        else if (a < LP_MIN)
            c = LP_MIN;
        else
            c = a;
        return c[WIDTH-1:0];
    endfunction

    function automatic logic [1:0] f_wclamp(input logic [1:0] w);
        return (w == 2'd3) ? 2'd2 : w;
    endfunction

    state_t                      r_state;
    state_t                      w_next_state;
    logic signed [WIDTH-1:0]     r_s2;
    logic signed [WIDTH-1:0]     r_s3;
    logic [1:0]                  r_w;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [WIDTH-1:0]     r_sample;
    logic                        r_out_valid;
    logic                        r_clipped;
    logic                        r_dropped;
    logic                        w_busy;

    assign w_busy     = (r_state != IDLE);
    assign busy       = w_busy;
    assign out_valid  = r_out_valid;
    assign sample_out = r_sample;
    assign clipped    = r_clipped;
    assign dropped    = r_dropped;

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = ADD2;
            ADD2:    w_next_state = ADD3;
            ADD3:    w_next_state = SAT;
            SAT:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s2        <= '0;
            r_s3        <= '0;
            r_w         <= '0;
            r_acc       <= '0;
            r_sample    <= '0;
            r_out_valid <= 1'b0;
            r_clipped   <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_clipped   <= 1'b0;
            // Inputs arriving mid-sequence are discarded but remembered.
            if (in_valid && w_busy)
                r_dropped <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s2  <= s2;
                        r_s3  <= s3;
                        r_w   <= f_wclamp(weight);
                        r_acc <= f_sext(s1);
                    end
                end
                ADD2: begin
                    if (r_w >= 2'd1)
                        r_acc <= r_acc + f_half(r_s2);
                end
                ADD3: begin
                    if (r_w >= 2'd2)
                        r_acc <= r_acc + f_quarter(r_s3);
                end
                SAT: begin
                    r_sample    <= f_sat(r_acc);
                    r_clipped   <= f_clip(r_acc);
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_mixer.sv
// Directed bench for harmonic_mixer: latency, weighting, clamping, drop and reset behaviour.
module tb_harmonic_mixer;

    logic               clk;
    logic               reset;
    logic [1:0]         weight;
    logic               in_valid;
    logic signed [15:0] s1;
    logic signed [15:0] s2;
    logic signed [15:0] s3;
    logic               busy;
    logic               out_valid;
    logic signed [15:0] sample_out;
    logic               clipped;
    logic               dropped;

    int n_total;
    int n_bad;
    int n_pulses;

    harmonic_mixer #(.WIDTH(16), .ACC_WIDTH(18)) dut (
        .clk        (clk),
        .reset      (reset),
        .weight     (weight),
        .in_valid   (in_valid),
        .s1         (s1),
        .s2         (s2),
        .s3         (s3),
        .busy       (busy),
        .out_valid  (out_valid),
        .sample_out (sample_out),
        .clipped    (clipped),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one accepted sample and checks the full 4-cycle result timing.
    task automatic run_sample(input string tag,
                              input logic signed [15:0] a,
                              input logic signed [15:0] b,
                              input logic signed [15:0] c,
                              input logic [1:0] w,
                              input logic [1:0] w_mid,
                              input int exp_out,
                              input int exp_clip);
        s1 = a; s2 = b; s3 = c; weight = w; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        weight   = w_mid;
        chk({tag, "_busy0"}, int'(busy), 1);
        chk({tag, "_ov0"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_ov1"}, int'(out_valid), 0);
        @(negedge clk);
        chk({tag, "_ov2"}, int'(out_valid), 0);
        chk({tag, "_busy2"}, int'(busy), 1);
        @(negedge clk);
        chk({tag, "_ov3"}, int'(out_valid), 1);
        chk({tag, "_out"}, int'(sample_out), exp_out);
        chk({tag, "_clip"}, int'(clipped), exp_clip);
        chk({tag, "_busy3"}, int'(busy), 0);
        @(negedge clk);
        chk({tag, "_ov4"}, int'(out_valid), 0);
        chk({tag, "_clip4"}, int'(clipped), 0);
        chk({tag, "_hold"}, int'(sample_out), exp_out);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b0; in_valid = 1'b0; weight = 2'd0;
        s1 = '0; s2 = '0; s3 = '0;

        // reset, then idle
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_out", int'(sample_out), 0);
        chk("rst_clip", int'(clipped), 0);
        chk("rst_drop", int'(dropped), 0);
        n_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) n_pulses++;
        end
        chk("idle_pulses", n_pulses, 0);
        chk("idle_busy", int'(busy), 0);

        // weight sweep
        run_sample("w0", 16'sd1000, 16'sd400, 16'sd800, 2'd0, 2'd0, 1000, 0);
        run_sample("w1", 16'sd1000, 16'sd400, 16'sd800, 2'd1, 2'd1, 1200, 0);
        run_sample("w2", 16'sd1000, 16'sd400, 16'sd800, 2'd2, 2'd2, 1400, 0);
        run_sample("w3", 16'sd1000, 16'sd400, 16'sd800, 2'd3, 2'd3, 1400, 0);

        // saturation and shift rounding
        run_sample("satp", 16'sd32767, 16'sd32767, 16'sd32767, 2'd2, 2'd2, 32767, 1);
        run_sample("satn", -16'sd32768, -16'sd32768, -16'sd32768, 2'd2, 2'd2, -32768, 1);
        run_sample("neg1", -16'sd1, -16'sd1, 16'sd0, 2'd1, 2'd1, -2, 0);
        run_sample("rndw2", -16'sd3, -16'sd3, -16'sd3, 2'd2, 2'd2, -6, 0);
        chk("drop_none", int'(dropped), 0);

        // back-to-back: second pulse lands while busy
        s1 = 16'sd5; s2 = 16'sd0; s3 = 16'sd0; weight = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_pulses = 0;
        if (out_valid) n_pulses++;
        @(negedge clk);
        if (out_valid) n_pulses++;
        s1 = 16'sd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (out_valid) n_pulses++;
        chk("b2b_drop_set", int'(dropped), 1);
        @(negedge clk);
        if (out_valid) n_pulses++;
        chk("b2b_out", int'(sample_out), 5);
        chk("b2b_pulses", n_pulses, 1);
        run_sample("b2b_next", 16'sd9, 16'sd0, 16'sd0, 2'd0, 2'd0, 9, 0);
        chk("b2b_drop_sticky", int'(dropped), 1);

        // weight changes after acceptance must not matter
        run_sample("wmid", 16'sd100, 16'sd100, 16'sd0, 2'd0, 2'd2, 100, 0);

        // reset in the middle of a sample
        s1 = 16'sd777; s2 = 16'sd0; s3 = 16'sd0; weight = 2'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_drop", int'(dropped), 0);
        chk("mrst_out", int'(sample_out), 0);
        n_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) n_pulses++;
        end
        chk("mrst_pulses", n_pulses, 0);
        run_sample("after_rst", 16'sd300, 16'sd200, 16'sd100, 2'd2, 2'd2, 425, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/harmonic_mixer.md
# harmonic_mixer

Downstream consumer of the harmonic weight control (`weight`, range 0–2). It combines one fundamental and two harmonic sample streams into a single signed audio sample, with the harmonic content set by `weight`. It sits between the note/harmonic sample generators and the codec output path. Each accepted sample is processed by a small multi-cycle accumulate-and-saturate FSM and emitted with a one-cycle valid strobe.

## Interface
Parameters:
- `WIDTH`, 16, sample width in bits (signed two's complement).
- `ACC_WIDTH`, `WIDTH`+2, internal accumulator width (must be at least `WIDTH`+2).

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low; `reset`=0 at a rising edge resets the block.
- `weight`  input  2  harmonic weight from the control stage: 0, 1 or 2; 3 is treated as 2.
- `in_valid`  input  1  one-cycle strobe; `s1`, `s2`, `s3` are valid in the same cycle.
- `s1`  input  WIDTH  fundamental sample, signed.
- `s2`  input  WIDTH  2nd-harmonic sample, signed.
- `s3`  input  WIDTH  3rd-harmonic sample, signed.
- `busy`  output  1  high whenever state is not IDLE.
- `out_valid`  output  1  one-cycle strobe; `sample_out` is updated in the same cycle.
- `sample_out`  output  WIDTH  mixed, saturated sample, signed.
- `clipped`  output  1  high with `out_valid` when saturation occurred; low otherwise.
- `dropped`  output  1  sticky: set when `in_valid` arrives while busy; cleared only by reset.

## Operation
- States: IDLE, ADD2, ADD3, SAT.
- IDLE, `in_valid`=1:
  - latch `s2`, `s3`;
  - latch `w` = min(`weight`, 2);
  - `acc` <= sign-extend(`s1`);
  - go to ADD2.
- IDLE, `in_valid`=0: stay in IDLE.
- ADD2: if `w`>=1, `acc` <= `acc` + (sign-extend(`s2`) >>> 1); otherwise `acc` is unchanged. Go to ADD3.
- ADD3: if `w`>=2, `acc` <= `acc` + (sign-extend(`s3`) >>> 2); otherwise `acc` is unchanged. Go to SAT.
- SAT:
  - `sample_out` <= `acc` clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1];
  - `clipped` <= 1 if clamping changed the value;
  - `out_valid` <= 1;
  - go to IDLE.
- Shifts are arithmetic; each shifted value rounds toward -inf (LSBs are truncated).
- `weight` is sampled only at acceptance. Changes mid-operation do not affect the sample in flight.
- `in_valid` in ADD2, ADD3 or SAT: the input is ignored, `dropped` <= 1, and the in-flight sample is unaffected.
- Worst-case sum is 32767+16383+8191 = 57341, which fits the 18-bit `acc`. Overflow is handled only by the final clamp.

## Timing
- Reset (`reset`=0 at an edge) has priority over all other activity, including mid-operation. An in-flight sample is discarded, and no `out_valid` is produced for it.
- Reset values: state=IDLE, `busy`=0, `out_valid`=0, `clipped`=0, `dropped`=0, `sample_out`=0, `acc`=0.
- Latency: with `in_valid` sampled at edge E0, ADD2 executes at E1, ADD3 at E2 and SAT at E3. `out_valid`, `sample_out` and `clipped` are registered at E3 and are high/valid for the one cycle after E3.
- `busy` is high for the cycles after E0, E1 and E2, and is low after E3. A new `in_valid` is accepted at E4 at the earliest.
- Throughput: 1 sample per 4 cycles.
- `sample_out` holds its value between `out_valid` strobes.
- `out_valid` and `clipped` are low in every cycle other than the SAT result cycle.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, then release. All outputs are 0 and `busy`=0. No `out_valid` appears over 10 idle cycles.
- Weight sweep, with `s1`=1000, `s2`=400, `s3`=800:
  - `weight`=0 -> `sample_out`=1000;
  - `weight`=1 -> 1200;
  - `weight`=2 -> 1400;
  - `weight`=3 -> 1400.
  - In every case `out_valid` is high exactly 3 edges after acceptance, and `clipped`=0.
- Saturation:
  - `s1`=32767, `s2`=32767, `s3`=32767, `weight`=2 -> `sample_out`=32767, `clipped`=1.
  - `s1`=-32768, `s2`=-32768, `s3`=-32768, `weight`=2 -> `sample_out`=-32768, `clipped`=1.
  - `s1`=-1, `s2`=-1, `weight`=1 -> `sample_out`=-2, `clipped`=0 (checks arithmetic shift).
- Back-to-back inputs: pulse `in_valid` at E0 (`s1`=5, `weight`=0) and again at E2 (`s1`=9).
  - Only one `out_valid` appears, with `sample_out`=5, and `dropped`=1.
  - A pulse at E4 (`s1`=9) is accepted -> `sample_out`=9; `dropped` stays 1.
- Weight change mid-flight: accept with `weight`=0 (`s1`=100, `s2`=100), then set `weight`=2 at E1 -> `sample_out`=100.
- Reset mid-operation: accept a sample, then drive `reset`=0 at E2.
  - No `out_valid` appears, and `busy`=0 and `dropped`=0 after reset.
  - The next accepted sample is processed normally.
